alu_result_checker: RTL and testbench

ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

---
 rtl/alu_result_checker.sv | 178 +++++++++++++++++
 tb/tb_alu_result_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// ALU result checker: samples ALU stimulus/response pairs, recomputes
// the expected result and tallies pass/fail/skip with first-fail capture.
module alu_result_checker #(
  parameter int CNT_W      = 16,
  parameter int NUM_CHECKS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             chk_valid,
  output logic             chk_ready,
  input  logic [2:0]       op,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [31:0]      dut_result,
  input  logic             dut_ifBeq,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] skip_count,
  output logic             error,
  output logic [2:0]       first_fail_op,
  output logic [31:0]      first_fail_exp,
  output logic [31:0]      first_fail_act,
  output logic             done
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Total is kept unsaturated so completion works even when tallies clip.
  localparam int TOT_W = $clog2(NUM_CHECKS + 1);
  localparam logic [TOT_W:0] LAST = (TOT_W + 1)'(NUM_CHECKS);

  state_t r_state;
  state_t w_next;

  logic [2:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_res;
  logic             r_beq;
  logic [TOT_W-1:0] r_total;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic [CNT_W-1:0] r_skip;
  logic             r_error;
  logic [2:0]       r_ff_op;
  logic [31:0]      r_ff_exp;
  logic [31:0]      r_ff_act;

  logic [31:0] w_exp;
  logic        w_exp_beq;
  logic        w_skip;
  logic        w_match;
  logic        w_last;
  logic        w_cmp;

  // Reference ALU model on the registered sample.
  always_comb begin
    w_exp  = 32'd0;
    w_skip = 1'b0;
    case (r_op)
      3'b000:  w_exp = r_a & r_b;
      3'b001:  w_exp = r_a | r_b;
      3'b010:  w_exp = r_a + r_b;
      3'b110:  w_exp = r_a - r_b;
      3'b011:  w_exp = r_a ^ r_b;
      default: w_skip = 1'b1;
    endcase
  end

  assign w_exp_beq = (r_op == 3'b110) && (r_a == r_b);
  assign w_match   = (w_exp == r_res) && (w_exp_beq == r_beq);
  assign w_cmp     = (r_state == CMP);
  assign w_last    = ({1'b0, r_total} + 1'b1) == LAST;

  // Next-state and handshake/status decode.
  always_comb begin
    w_next    = r_state;
    chk_ready = 1'b0;
    done      = 1'b0;
    case (r_state)
      RUN: begin
        chk_ready = 1'b1;
        if (chk_valid) w_next = CMP;
      end
      CMP:     w_next = w_last ? DONE : RUN;
      DONE:    done = 1'b1;
      default: w_next = RUN;
    endcase
  end

  // State register; clear restarts from RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_state <= RUN;
    else if (clear) r_state <= RUN;
    else            r_state <= w_next;
  end

  // Sample capture on an accepted handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_beq <= 1'b0;
    end else if (clear) begin
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_beq <= 1'b0;
    end else if (r_state == RUN && chk_valid) begin
      r_op  <= op;
      r_a   <= a;
      r_b   <= b;
      r_res <= dut_result;
      r_beq <= dut_ifBeq;
    end
  end

  // Saturating tallies plus the unsaturated completion count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total <= '0;
      r_pass  <= '0;
      r_fail  <= '0;
      r_skip  <= '0;
    end else if (clear) begin
      r_total <= '0;
      r_pass  <= '0;
      r_fail  <= '0;
      r_skip  <= '0;
    end else if (w_cmp) begin
      r_total <= r_total + 1'b1;
      if (w_skip) begin
        if (r_skip != '1) r_skip <= r_skip + 1'b1;
      end else if (w_match) begin
        if (r_pass != '1) r_pass <= r_pass + 1'b1;
      end else begin
        if (r_fail != '1) r_fail <= r_fail + 1'b1;
      end
    end
  end

  // Sticky error and first-mismatch capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_error  <= 1'b0;
      r_ff_op  <= '0;
      r_ff_exp <= '0;
      r_ff_act <= '0;
    end else if (clear) begin
      r_error  <= 1'b0;
      r_ff_op  <= '0;
      r_ff_exp <= '0;
      r_ff_act <= '0;
    end else if (w_cmp && !w_skip && !w_match && !r_error) begin
      r_error  <= 1'b1;
      r_ff_op  <= r_op;
      r_ff_exp <= w_exp;
      r_ff_act <= r_res;
    end
  end

  assign pass_count     = r_pass;
  assign fail_count     = r_fail;
  assign skip_count     = r_skip;
  assign error          = r_error;
  assign first_fail_op  = r_ff_op;
  assign first_fail_exp = r_ff_exp;
  assign first_fail_act = r_ff_act;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: default instance plus a
// narrow-counter instance for saturation.
module tb_alu_result_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        chk_valid = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] dres = '0;
  logic        dbeq = 1'b0;
  logic        chk_ready;
  logic [15:0] pass_count;
  logic [15:0] fail_count;
  logic [15:0] skip_count;
  logic        error;
  logic [2:0]  ff_op;
  logic [31:0] ff_exp;
  logic [31:0] ff_act;
  logic        done;

  logic        v2 = 1'b0;
  logic        rdy2;
  logic [1:0]  pass2;
  logic [1:0]  fail2;
  logic [1:0]  skip2;
  logic        err2;
  logic [2:0]  ffop2;
  logic [31:0] ffexp2;
  logic [31:0] ffact2;
  logic        done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_checker dut (
    .clk(clk), .reset(reset), .clear(clear),
    .chk_valid(chk_valid), .chk_ready(chk_ready),
    .op(op), .a(a), .b(b),
    .dut_result(dres), .dut_ifBeq(dbeq),
    .pass_count(pass_count), .fail_count(fail_count),
    .skip_count(skip_count), .error(error),
    .first_fail_op(ff_op), .first_fail_exp(ff_exp),
    .first_fail_act(ff_act), .done(done)
  );

  alu_result_checker #(.CNT_W(2), .NUM_CHECKS(6)) dut2 (
    .clk(clk), .reset(reset), .clear(clear),
    .chk_valid(v2), .chk_ready(rdy2),
    .op(op), .a(a), .b(b),
    .dut_result(dres), .dut_ifBeq(dbeq),
    .pass_count(pass2), .fail_count(fail2),
    .skip_count(skip2), .error(err2),
    .first_fail_op(ffop2), .first_fail_exp(ffexp2),
    .first_fail_act(ffact2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Correct ALU behaviour, used to play a fault-free ALU.
  function automatic logic [31:0] alu(input logic [2:0] o,
                                      input logic [31:0] x,
                                      input logic [31:0] y);
    case (o)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b011:  return x ^ y;
      default: return 32'd0;
    endcase
  endfunction

  // One handshake on the main instance; returns at the negedge after CMP.
  task automatic send(input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] r,
                      input logic q);
    @(negedge clk);
    chk_valid = 1'b1;
    op = o; a = x; b = y; dres = r; dbeq = q;
    @(negedge clk);
    chk_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send2(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] r);
    @(negedge clk);
    v2 = 1'b1;
    op = o; a = x; b = y; dres = r; dbeq = 1'b0;
    @(negedge clk);
    v2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic [2:0] ops [5];

  initial begin
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010;
    ops[3] = 3'b110; ops[4] = 3'b011;

    #12;
    chk("rst_ready", 32'(chk_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass_count), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_pass2", 32'(pass2), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Latency: counter unchanged and ready low while in CMP.
    @(negedge clk);
    chk_valid = 1'b1;
    op = 3'b000; a = 0; b = 0; dres = 0; dbeq = 0;
    @(negedge clk);
    chk_valid = 1'b0;
    chk("cmp_ready", 32'(chk_ready), 32'd0);
    chk("cmp_pass", 32'(pass_count), 32'd0);
    @(negedge clk);
    chk("lat_pass", 32'(pass_count), 32'd1);
    chk("lat_ready", 32'(chk_ready), 32'd1);

    // Remaining 19 of the 20 correct checks over ops x {0,1}^2.
    for (int i = 1; i < 20; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      logic [2:0]  o;
      o = ops[i / 4];
      x = 32'((i % 4) / 2);
      y = 32'(i % 2);
      send(o, x, y, alu(o, x, y), (o == 3'b110) && (x == y));
      if (i == 18) chk("done_early", 32'(done), 32'd0);
    end
    chk("all_pass", 32'(pass_count), 32'd20);
    chk("all_fail", 32'(fail_count), 32'd0);
    chk("all_skip", 32'(skip_count), 32'd0);
    chk("all_err", 32'(error), 32'd0);
    chk("all_done", 32'(done), 32'd1);
    chk("done_ready", 32'(chk_ready), 32'd0);

    // DONE ignores new samples.
    send(3'b000, 1, 1, 0, 0);
    chk("done_hold_pass", 32'(pass_count), 32'd20);
    chk("done_hold_fail", 32'(fail_count), 32'd0);
    chk("done_hold_done", 32'(done), 32'd1);

    // Wraparound add passes; beq mismatch fails and is captured.
    do_clear();
    chk("clr_pass", 32'(pass_count), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    send(3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    chk("wrap_pass", 32'(pass_count), 32'd1);
    send(3'b110, 32'd5, 32'd5, 32'd0, 1'b0);
    chk("beq_fail", 32'(fail_count), 32'd1);
    chk("beq_err", 32'(error), 32'd1);
    chk("beq_ffop", 32'(ff_op), 32'd6);
    chk("beq_ffexp", ff_exp, 32'd0);
    chk("beq_ffact", ff_act, 32'd0);

    // Two fails: capture holds the first.
    do_clear();
    chk("clr_err", 32'(error), 32'd0);
    send(3'b000, 32'd1, 32'd1, 32'd0, 1'b0);
    send(3'b001, 32'd0, 32'd1, 32'd0, 1'b0);
    chk("two_fail", 32'(fail_count), 32'd2);
    chk("two_ffexp", ff_exp, 32'd1);
    chk("two_ffop", 32'(ff_op), 32'd0);
    chk("two_ffact", ff_act, 32'd0);

    // Unused opcode counts as skip only.
    do_clear();
    send(3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_0000, 1'b1);
    chk("skip_cnt", 32'(skip_count), 32'd1);
    chk("skip_err", 32'(error), 32'd0);
    chk("skip_fail", 32'(fail_count), 32'd0);

    // Async reset mid-CMP after three passes.
    do_clear();
    for (int i = 0; i < 3; i++) send(3'b001, 32'(i), 32'd8, 32'(i) | 32'd8, 1'b0);
    chk("pre_rst_pass", 32'(pass_count), 32'd3);
    @(negedge clk);
    chk_valid = 1'b1;
    op = 3'b000; a = 1; b = 1; dres = 1; dbeq = 0;
    @(posedge clk);
    #2;
    chk_valid = 1'b0;
    chk("in_cmp", 32'(chk_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("arst_pass", 32'(pass_count), 32'd0);
    chk("arst_ready", 32'(chk_ready), 32'd1);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst_drop", 32'(pass_count), 32'd0);

    // Clear beats a simultaneous valid.
    send(3'b010, 32'd2, 32'd3, 32'd5, 1'b0);
    chk("pre_clr_pass", 32'(pass_count), 32'd1);
    @(negedge clk);
    clear = 1'b1;
    chk_valid = 1'b1;
    op = 3'b010; a = 1; b = 1; dres = 2; dbeq = 0;
    @(negedge clk);
    clear = 1'b0;
    chk_valid = 1'b0;
    chk("clrv_pass", 32'(pass_count), 32'd0);
    chk("clrv_ready", 32'(chk_ready), 32'd1);
    @(negedge clk);
    chk("clrv_drop", 32'(pass_count), 32'd0);

    // Narrow counters saturate while completion still fires.
    do_clear();
    for (int i = 0; i < 6; i++) begin
      send2(3'b010, 32'd1, 32'd2, 32'd3);
      if (i == 2) chk("sat_p3", 32'(pass2), 32'd3);
      if (i == 4) chk("sat_notdone", 32'(done2), 32'd0);
    end
    chk("sat_pass", 32'(pass2), 32'd3);
    chk("sat_done", 32'(done2), 32'd1);
    chk("sat_err", 32'(err2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
